spi_slave_mode0: RTL and testbench

SPI mode 0 (CPOL=0, CPHA=0) slave endpoint, the responder counterpart of the team's mode 0 master used for the PmodJSTK link. It oversamples SCLK/SS/MOSI on the fabric clock, shifts transmit bytes out on MISO MSB-first and assembles received MOSI bytes, with a single-entry transmit holding register. It lets a Nexys3 design emulate a Pmod peripheral, or loop back against the master for board-level test.

---
 rtl/spi_slave_mode0.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_slave_mode0.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mode0.sv
// SPI mode 0 (CPOL=0, CPHA=0) slave endpoint.
// SCLK, SS and MOSI are oversampled on the fabric clock. Transmit bytes leave
// on MISO MSB-first from a shift register fed by a single-entry holding
// register. Received MOSI bits are assembled into bytes and presented on
// o_dout with a one-cycle o_dValid strobe.
module spi_slave_mode0 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rstN,
  input  logic       i_sclk,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_misoEn,
  input  logic [7:0] i_din,
  input  logic       i_load,
  output logic       o_txRdy,
  output logic [7:0] o_dout,
  output logic       o_dValid,
  output logic       o_busy,
  output logic       o_under
);

  // RESYNC waits for SS to read high through a settled synchronizer,
  // so a frame already in progress at reset is never joined half way.
  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    ACTIVE
  } stateT;

  // The synchronizers come out of reset holding their reset values, so the
  // synced SS only reflects the real pin after SYNC_STAGES clocks.
  localparam logic [1:0] SETTLE_CYCLES = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkHist;
  logic                   r_ssHist;

  logic w_sclkS;
  logic w_ssS;
  logic w_mosiS;
  logic w_sclkRise;
  logic w_sclkFall;
  logic w_ssRise;
  logic w_ssFall;

  stateT r_state;
  stateT w_nextState;

  logic [1:0] r_settleCnt;

  logic [7:0] r_txSr;
  logic [7:0] r_rxSr;
  logic [7:0] r_hold;
  logic [7:0] r_dout;
  logic [2:0] r_bitCnt;
  logic       r_txRdy;
  logic       r_dValid;
  logic       r_under;

  logic w_frameStart;
  logic w_rxRise;
  logic w_txShift;
  logic w_byteBoundary;
  logic w_xfer;
  logic w_loadAcc;

  // Synchronizer chains plus one history flop on SCLK and SS for edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_sclkSync <= '0;
      r_ssSync   <= '1;
      r_mosiSync <= '0;
      r_sclkHist <= 1'b0;
      r_ssHist   <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], i_sclk};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], i_ss};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], i_mosi};
      r_sclkHist <= r_sclkSync[SYNC_STAGES-1];
      r_ssHist   <= r_ssSync[SYNC_STAGES-1];
    end
  end

  assign w_sclkS    = r_sclkSync[SYNC_STAGES-1];
  assign w_ssS      = r_ssSync[SYNC_STAGES-1];
  assign w_mosiS    = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclkS & ~r_sclkHist;
  assign w_sclkFall = ~w_sclkS & r_sclkHist;
  assign w_ssRise   = w_ssS & ~r_ssHist;
  assign w_ssFall   = ~w_ssS & r_ssHist;

  // Count clocks spent in RESYNC until the synchronizers hold real pin samples.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_settleCnt <= 2'd0;
    end else if (r_state != RESYNC) begin
      r_settleCnt <= 2'd0;
    end else if (r_settleCnt != SETTLE_CYCLES) begin
      r_settleCnt <= r_settleCnt + 2'd1;
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_state <= RESYNC;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-cycle action decode; SS rise outranks any SCLK edge.
  always_comb begin
    w_nextState    = r_state;
    w_frameStart   = 1'b0;
    w_rxRise       = 1'b0;
    w_txShift      = 1'b0;
    w_byteBoundary = 1'b0;
    case (r_state)
      RESYNC: begin
        if ((r_settleCnt == SETTLE_CYCLES) && w_ssS) begin
          w_nextState = IDLE;
        end
      end
      IDLE: begin
        if (w_ssFall) begin
          w_nextState  = ACTIVE;
          w_frameStart = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_ssRise) begin
          w_nextState = IDLE;
        end else if (w_sclkRise) begin
          w_rxRise = 1'b1;
        end else if (w_sclkFall) begin
          if (r_bitCnt == 3'd0) begin
            w_byteBoundary = 1'b1;
          end else begin
            w_txShift = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = RESYNC;
      end
    endcase
  end

  assign w_xfer    = w_frameStart | w_byteBoundary;
  assign w_loadAcc = i_load & r_txRdy;

  // Receive path: shift MOSI on SCLK rise and publish every eighth bit as a byte.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_rxSr   <= 8'h00;
      r_bitCnt <= 3'd0;
      r_dout   <= 8'h00;
      r_dValid <= 1'b0;
    end else begin
      r_dValid <= 1'b0;
      if (w_frameStart) begin
        r_bitCnt <= 3'd0;
      end else if (w_rxRise) begin
        r_rxSr <= {r_rxSr[6:0], w_mosiS};
        if (r_bitCnt == 3'd7) begin
          r_dout   <= {r_rxSr[6:0], w_mosiS};
          r_dValid <= 1'b1;
          r_bitCnt <= 3'd0;
        end else begin
          r_bitCnt <= r_bitCnt + 3'd1;
        end
      end
    end
  end

  // Transmit shifter: reload at frame start and byte boundaries, else shift on SCLK fall.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_txSr <= 8'h00;
    end else if (w_xfer) begin
      r_txSr <= r_txRdy ? 8'h00 : r_hold;
    end else if (w_txShift) begin
      r_txSr <= {r_txSr[6:0], 1'b0};
    end
  end

  // Holding register and sticky underrun flag; an underrun outranks a same-cycle LOAD.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_hold  <= 8'h00;
      r_txRdy <= 1'b1;
      r_under <= 1'b0;
    end else begin
      if (w_loadAcc) begin
        r_hold <= i_din;
      end
      if (w_loadAcc) begin
        r_txRdy <= 1'b0;
      end else if (w_xfer) begin
        r_txRdy <= 1'b1;
      end
      if (w_xfer && r_txRdy) begin
        r_under <= 1'b1;
      end else if (w_loadAcc) begin
        r_under <= 1'b0;
      end
    end
  end

  assign o_miso   = r_txSr[7];
  assign o_busy   = (r_state == ACTIVE);
  assign o_misoEn = o_busy;
  assign o_txRdy  = r_txRdy;
  assign o_dout   = r_dout;
  assign o_dValid = r_dValid;
  assign o_under  = r_under;

endmodule

// File: tb/tb_spi_slave_mode0.sv
// Testbench for spi_slave_mode0: a behavioural mode 0 master drives frames,
// a loader feeds the holding register, and each scenario task compares what
// the master and a DVALID monitor observed against bytes it chose itself.
module tb_spi_slave_mode0;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] din = 8'h00;
  logic       load = 1'b0;
  logic       miso;
  logic       misoEn;
  logic       txRdy;
  logic [7:0] dout;
  logic       dValid;
  logic       busy;
  logic       under;

  int nChecks = 0;
  int nFail = 0;

  logic [7:0] mMosi [0:7];
  logic [7:0] mMiso [0:7];
  logic [7:0] mTx [0:7];
  logic       lastUnder;

  logic [7:0] dvQ [$];
  logic       prevDv = 1'b0;
  int         dvWide = 0;

  spi_slave_mode0 #(.SYNC_STAGES(S)) dut (
    .i_clk   (clk),
    .i_rstN  (rstN),
    .i_sclk  (sclk),
    .i_ss    (ss),
    .i_mosi  (mosi),
    .o_miso  (miso),
    .o_misoEn(misoEn),
    .i_din   (din),
    .i_load  (load),
    .o_txRdy (txRdy),
    .o_dout  (dout),
    .o_dValid(dValid),
    .o_busy  (busy),
    .o_under (under)
  );

  // Fabric clock, 10 ns period.
  always #5 clk = ~clk;

  // Record every received byte and count DVALID pulses wider than one cycle.
  always @(negedge clk) begin
    prevDv <= dValid;
    if (dValid === 1'b1) begin
      dvQ.push_back(dout);
      if (prevDv === 1'b1) dvWide <= dvWide + 1;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic loadByte(input logic [7:0] v);
    @(negedge clk);
    din  = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Mode 0 master: MOSI set half a period before each rise, MISO sampled at the rise.
  task automatic masterFrame(input int nBytes, input int halfP, input int stopAfter);
    int rises;
    bit stop;
    rises = 0;
    stop = 1'b0;
    lastUnder = 1'bx;
    @(negedge clk);
    ss = 1'b0;
    mosi = mMosi[0][7];
    repeat (2 * halfP) @(negedge clk);
    for (int b = 0; b < nBytes && !stop; b++) begin
      for (int k = 7; k >= 0 && !stop; k--) begin
        if (stopAfter >= 0 && rises == stopAfter) begin
          stop = 1'b1;
        end else begin
          mosi = mMosi[b][k];
          repeat (halfP) @(negedge clk);
          sclk = 1'b1;
          mMiso[b][k] = miso;
          rises++;
          repeat (halfP) @(negedge clk);
          if (b == nBytes - 1 && k == 0) lastUnder = under;
          sclk = 1'b0;
        end
      end
    end
    repeat (halfP) @(negedge clk);
    ss = 1'b1;
    repeat (4 * halfP) @(negedge clk);
  endtask

  // Load mTx[1..n-1], each as soon as the holding register reports empty.
  task automatic feedLoads(input int n);
    int waited;
    for (int i = 1; i < n; i++) begin
      waited = 0;
      while (txRdy !== 1'b1 && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      nChecks++;
      if (txRdy !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL txrdy_wait: txRdy=%0b, needed 1 within 2000 cycles", txRdy);
      end else begin
        loadByte(mTx[i]);
      end
    end
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    nChecks++; if (miso !== 1'b0) begin nFail++; $display("[TB] FAIL reset_miso: got %0b expected 0", miso); end
    nChecks++; if (misoEn !== 1'b0) begin nFail++; $display("[TB] FAIL reset_misoEn: got %0b expected 0", misoEn); end
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    nChecks++; if (txRdy !== 1'b1) begin nFail++; $display("[TB] FAIL reset_txRdy: got %0b expected 1", txRdy); end
    nChecks++; if (dout !== 8'h00) begin nFail++; $display("[TB] FAIL reset_dout: got %02h expected 00", dout); end
    nChecks++; if (dValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_dValid: got %0b expected 0", dValid); end
    nChecks++; if (under !== 1'b0) begin nFail++; $display("[TB] FAIL reset_under: got %0b expected 0", under); end
    dvQ.delete();
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    nChecks++; if (dvQ.size() != 0) begin nFail++; $display("[TB] FAIL idle_sclk_dvalid: got %0d pulses expected 0", dvQ.size()); end
    nChecks++; if (miso !== 1'b0) begin nFail++; $display("[TB] FAIL idle_sclk_miso: got %0b expected 0", miso); end
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL idle_sclk_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_byte;
    $display("[TB] test_single_byte");
    dvQ.delete();
    loadByte(8'hA5);
    nChecks++; if (txRdy !== 1'b0) begin nFail++; $display("[TB] FAIL load_txRdy: got %0b expected 0", txRdy); end
    mMosi[0] = 8'h3C;
    fork
      masterFrame(1, 8, -1);
      begin
        @(negedge ss);
        repeat (S) @(negedge clk);
        nChecks++; if (txRdy !== 1'b0) begin nFail++; $display("[TB] FAIL txrdy_early: got %0b expected 0", txRdy); end
        @(negedge clk);
        nChecks++; if (txRdy !== 1'b1) begin nFail++; $display("[TB] FAIL txrdy_on_time: got %0b expected 1", txRdy); end
        nChecks++; if (busy !== 1'b1 || misoEn !== 1'b1) begin nFail++; $display("[TB] FAIL busy_start: got busy=%0b en=%0b expected 1 1", busy, misoEn); end
        nChecks++; if (miso !== 1'b1) begin nFail++; $display("[TB] FAIL miso_msb_first: got %0b expected 1", miso); end
      end
    join
    nChecks++; if (mMiso[0] !== 8'hA5) begin nFail++; $display("[TB] FAIL single_miso: got %02h expected a5", mMiso[0]); end
    nChecks++; if (dvQ.size() != 1) begin nFail++; $display("[TB] FAIL single_dv_count: got %0d expected 1", dvQ.size()); end
    nChecks++; if (dvQ.size() > 0 && dvQ[0] !== 8'h3C) begin nFail++; $display("[TB] FAIL single_dout: got %02h expected 3c", dvQ[0]); end
    nChecks++; if (lastUnder !== 1'b0) begin nFail++; $display("[TB] FAIL single_under: got %0b expected 0", lastUnder); end
    nChecks++; if (busy !== 1'b0 || misoEn !== 1'b0) begin nFail++; $display("[TB] FAIL single_end_busy: got busy=%0b en=%0b expected 0 0", busy, misoEn); end
    nChecks++; if (dvWide != 0) begin nFail++; $display("[TB] FAIL dvalid_width: got %0d wide pulses expected 0", dvWide); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rx [0:4];
    $display("[TB] test_back_to_back");
    rx[0] = 8'h80; rx[1] = 8'h01; rx[2] = 8'hFF; rx[3] = 8'h00; rx[4] = 8'h5A;
    dvQ.delete();
    for (int i = 0; i < 5; i++) begin
      mMosi[i] = rx[i];
      mTx[i] = 8'(8'h11 * (i + 1));
    end
    loadByte(mTx[0]);
    fork
      masterFrame(5, 8, -1);
      feedLoads(5);
    join
    for (int i = 0; i < 5; i++) begin
      nChecks++; if (mMiso[i] !== mTx[i]) begin nFail++; $display("[TB] FAIL b2b_miso[%0d]: got %02h expected %02h", i, mMiso[i], mTx[i]); end
    end
    nChecks++; if (dvQ.size() != 5) begin nFail++; $display("[TB] FAIL b2b_dv_count: got %0d expected 5", dvQ.size()); end
    for (int i = 0; i < 5; i++) begin
      nChecks++; if (i < dvQ.size() && dvQ[i] !== rx[i]) begin nFail++; $display("[TB] FAIL b2b_dout[%0d]: got %02h expected %02h", i, dvQ[i], rx[i]); end
    end
    nChecks++; if (lastUnder !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_under: got %0b expected 0", lastUnder); end
    nChecks++; if (dvWide != 0) begin nFail++; $display("[TB] FAIL dvalid_width: got %0d wide pulses expected 0", dvWide); end
  endtask

  task automatic test_underrun;
    int waited;
    $display("[TB] test_underrun");
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    dvQ.delete();
    nChecks++; if (under !== 1'b0 || txRdy !== 1'b1) begin nFail++; $display("[TB] FAIL under_pre: got under=%0b txRdy=%0b expected 0 1", under, txRdy); end
    mMosi[0] = 8'($urandom_range(0, 255));
    mMosi[1] = 8'($urandom_range(0, 255));
    fork
      masterFrame(2, 8, -1);
      begin
        waited = 0;
        while (busy !== 1'b1 && waited < 500) begin
          @(negedge clk);
          waited++;
        end
        nChecks++; if (under !== 1'b1) begin nFail++; $display("[TB] FAIL under_set: got %0b expected 1", under); end
        nChecks++; if (miso !== 1'b0) begin nFail++; $display("[TB] FAIL under_miso: got %0b expected 0", miso); end
        loadByte(8'h77);
        nChecks++; if (under !== 1'b0) begin nFail++; $display("[TB] FAIL under_clear: got %0b expected 0", under); end
        nChecks++; if (txRdy !== 1'b0) begin nFail++; $display("[TB] FAIL under_load_txRdy: got %0b expected 0", txRdy); end
      end
    join
    nChecks++; if (mMiso[0] !== 8'h00) begin nFail++; $display("[TB] FAIL under_byte0: got %02h expected 00", mMiso[0]); end
    nChecks++; if (mMiso[1] !== 8'h77) begin nFail++; $display("[TB] FAIL under_byte1: got %02h expected 77", mMiso[1]); end
    nChecks++; if (dvQ.size() != 2) begin nFail++; $display("[TB] FAIL under_dv_count: got %0d expected 2", dvQ.size()); end
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (i < dvQ.size() && dvQ[i] !== mMosi[i]) begin nFail++; $display("[TB] FAIL under_dout[%0d]: got %02h expected %02h", i, dvQ[i], mMosi[i]); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] x;
    logic [7:0] w;
    logic [7:0] z;
    logic [7:0] got;
    $display("[TB] test_abort");
    x = 8'($urandom_range(0, 255));
    w = 8'($urandom_range(0, 255));
    z = 8'($urandom_range(0, 255));
    dvQ.delete();
    mMosi[0] = 8'($urandom_range(0, 255));
    mMiso[0] = 8'h00;
    loadByte(x);
    fork
      masterFrame(1, 8, 5);
      begin
        mTx[1] = w;
        feedLoads(2);
      end
    join
    got = mMiso[0];
    nChecks++; if (got[7:3] !== x[7:3]) begin nFail++; $display("[TB] FAIL abort_miso_bits: got %02h expected %02h", got[7:3], x[7:3]); end
    nChecks++; if (dvQ.size() != 0) begin nFail++; $display("[TB] FAIL abort_dvalid: got %0d pulses expected 0", dvQ.size()); end
    nChecks++; if (busy !== 1'b0 || misoEn !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got busy=%0b en=%0b expected 0 0", busy, misoEn); end
    nChecks++; if (txRdy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_hold_kept: got txRdy=%0b expected 0", txRdy); end
    mMosi[0] = z;
    masterFrame(1, 8, -1);
    nChecks++; if (mMiso[0] !== w) begin nFail++; $display("[TB] FAIL abort_next_miso: got %02h expected %02h", mMiso[0], w); end
    nChecks++; if (dvQ.size() != 1) begin nFail++; $display("[TB] FAIL abort_next_dv_count: got %0d expected 1", dvQ.size()); end
    nChecks++; if (dvQ.size() > 0 && dvQ[0] !== z) begin nFail++; $display("[TB] FAIL abort_next_dout: got %02h expected %02h", dvQ[0], z); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] v;
    logic [7:0] z;
    $display("[TB] test_reset_midframe");
    dvQ.delete();
    loadByte(8'hC3);
    @(negedge clk);
    ss = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        nChecks++; if (busy !== 1'b0 || misoEn !== 1'b0) begin nFail++; $display("[TB] FAIL rst_mid_busy: got busy=%0b en=%0b expected 0 0", busy, misoEn); end
        nChecks++; if (miso !== 1'b0) begin nFail++; $display("[TB] FAIL rst_mid_miso: got %0b expected 0", miso); end
      end
      mosi = 1'($urandom_range(0, 1));
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (16) @(negedge clk);
    nChecks++; if (busy !== 1'b0 || misoEn !== 1'b0) begin nFail++; $display("[TB] FAIL rst_hold_busy: got busy=%0b en=%0b expected 0 0", busy, misoEn); end
    nChecks++; if (dvQ.size() != 0) begin nFail++; $display("[TB] FAIL rst_hold_dvalid: got %0d pulses expected 0", dvQ.size()); end
    nChecks++; if (txRdy !== 1'b1 || dout !== 8'h00) begin nFail++; $display("[TB] FAIL rst_hold_regs: got txRdy=%0b dout=%02h expected 1 00", txRdy, dout); end
    ss = 1'b1;
    repeat (32) @(negedge clk);
    v = 8'($urandom_range(0, 255));
    z = 8'($urandom_range(0, 255));
    loadByte(v);
    mMosi[0] = z;
    masterFrame(1, 8, -1);
    nChecks++; if (mMiso[0] !== v) begin nFail++; $display("[TB] FAIL rst_next_miso: got %02h expected %02h", mMiso[0], v); end
    nChecks++; if (dvQ.size() != 1) begin nFail++; $display("[TB] FAIL rst_next_dv_count: got %0d expected 1", dvQ.size()); end
    nChecks++; if (dvQ.size() > 0 && dvQ[0] !== z) begin nFail++; $display("[TB] FAIL rst_next_dout: got %02h expected %02h", dvQ[0], z); end
  endtask

  task automatic test_random;
    int n;
    int halfP;
    $display("[TB] test_random");
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(1, 4));
      halfP = int'($urandom_range(6, 12));
      for (int i = 0; i < n; i++) begin
        mTx[i] = 8'($urandom_range(0, 255));
        mMosi[i] = 8'($urandom_range(0, 255));
      end
      dvQ.delete();
      loadByte(mTx[0]);
      fork
        masterFrame(n, halfP, -1);
        feedLoads(n);
      join
      nChecks++; if (dvQ.size() != n) begin nFail++; $display("[TB] FAIL rand%0d_dv_count: got %0d expected %0d", it, dvQ.size(), n); end
      for (int i = 0; i < n; i++) begin
        nChecks++; if (mMiso[i] !== mTx[i]) begin nFail++; $display("[TB] FAIL rand%0d_miso[%0d]: got %02h expected %02h", it, i, mMiso[i], mTx[i]); end
        nChecks++; if (i < dvQ.size() && dvQ[i] !== mMosi[i]) begin nFail++; $display("[TB] FAIL rand%0d_dout[%0d]: got %02h expected %02h", it, i, dvQ[i], mMosi[i]); end
      end
      nChecks++; if (lastUnder !== 1'b0) begin nFail++; $display("[TB] FAIL rand%0d_under: got %0b expected 0", it, lastUnder); end
    end
    nChecks++; if (dvWide != 0) begin nFail++; $display("[TB] FAIL dvalid_width: got %0d wide pulses expected 0", dvWide); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
